// File: rtl/acc_display_driver_pkg.sv
// Shared definitions for the accumulator display driver: converter FSM
// states, active-low 7-segment codes and magnitude digit count.
package acc_display_driver_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  localparam int NUM_MAG_DIGITS = 5;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  // Map one BCD digit to its segment pattern; non-decimal codes blank.
  function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/acc_display_driver_bin2bcd.sv
// Sequential double-dabble converter: 16-bit unsigned binary to 5 BCD
// digits, one add-3/shift iteration per clock, VALID during COMMIT.
module bin2bcd_dd
  import acc_display_driver_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [15:0] BIN,
  output logic        BUSY,
  output logic        VALID,
  output logic [19:0] BCD
);

  state_t      state;
  logic [15:0] shreg;
  logic [3:0]  iter;

  // Add 3 to every nibble of 5 or more ahead of the shift.
  function automatic logic [19:0] dabble(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < NUM_MAG_DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Converter FSM: capture, 16 shift iterations, one commit cycle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      BUSY  <= 1'b0;
      VALID <= 1'b0;
      iter  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            shreg <= BIN;
            BCD   <= 20'd0;
            iter  <= 4'd0;
            BUSY  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          {BCD, shreg} <= {dabble(BCD), shreg} << 1;
          iter         <= iter + 4'd1;
          if (iter == 4'd15) begin
            state <= COMMIT;
            VALID <= 1'b1;
          end
        end
        COMMIT: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          VALID <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/acc_display_driver.sv
// Accumulator display driver: captures sign/magnitude on LOAD, converts to
// BCD, and scans sign plus digits onto a 6-digit common-anode display with
// leading-zero blanking. The old value is held until the commit cycle.
module acc_display_driver
  import acc_display_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int NUM_DIGITS  = 6
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] VALUE,
  input  logic        LOAD,
  output logic        BUSY,
  output logic        DONE,
  output logic [6:0]  SEG,
  output logic [5:0]  AN
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic signed [15:0] value_s;
  logic [15:0]        mag;
  logic               start;
  logic               neg_cap;
  logic               conv_busy;
  logic               conv_valid;
  logic [19:0]        conv_bcd;
  logic [19:0]        disp_bcd;
  logic               disp_neg;
  logic [CNT_W-1:0]   refresh_cnt;
  logic               wrap;
  logic [2:0]         idx;
  logic [2:0]         idx_next;

  assign value_s = VALUE;
  // Two's-complement negate; -32768 yields 0x8000, read as unsigned 32768.
  assign mag     = value_s[15] ? (~VALUE + 16'd1) : VALUE;
  assign start   = LOAD && !conv_busy;
  assign BUSY    = conv_busy;

  bin2bcd_dd u_conv (
    .CLK   (CLK),
    .RST   (RST),
    .START (start),
    .BIN   (mag),
    .BUSY  (conv_busy),
    .VALID (conv_valid),
    .BCD   (conv_bcd)
  );

  // Segment pattern for display position pos: digits up to the most
  // significant nonzero nibble, a minus just above it, blanks elsewhere.
  function automatic logic [6:0] digit_seg(input logic [2:0] pos,
                                           input logic [19:0] bcd,
                                           input logic neg);
    int         msd;
    logic [6:0] s;
    msd = 0;
    s   = SEG_BLANK;
    for (int i = 0; i < NUM_MAG_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = i;
    end
    for (int i = 0; i < NUM_MAG_DIGITS; i++) begin
      if (int'(pos) == i && i <= msd) s = seg_of_digit(bcd[4*i +: 4]);
    end
    if (neg && (bcd != 20'd0) && int'(pos) == msd + 1) s = SEG_MINUS;
    return s;
  endfunction

  assign wrap = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));

  // Next scan position: advance on refresh wrap, 0..NUM_DIGITS-1.
  always_comb begin
    idx_next = idx;
    if (wrap) idx_next = (int'(idx) == NUM_DIGITS - 1) ? 3'd0 : idx + 3'd1;
  end

  // Sign capture, committed display value and the DONE pulse.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      neg_cap  <= 1'b0;
      disp_bcd <= 20'd0;
      disp_neg <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      DONE <= conv_valid;
      if (start) neg_cap <= value_s[15];
      if (conv_valid) begin
        disp_bcd <= conv_bcd;
        disp_neg <= neg_cap;
      end
    end
  end

  // Refresh scan with registered SEG/AN; a commit redraws the current digit.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      refresh_cnt <= '0;
      idx         <= 3'd0;
      AN          <= 6'b111110;
      SEG         <= SEG_0;
    end else begin
      refresh_cnt <= wrap ? '0 : refresh_cnt + 1'b1;
      idx         <= idx_next;
      AN          <= ~(6'd1 << idx_next);
      if (conv_valid)  SEG <= digit_seg(idx_next, conv_bcd, neg_cap);
      else if (wrap)   SEG <= digit_seg(idx_next, disp_bcd, disp_neg);
    end
  end

endmodule

// File: tb/tb_acc_display_driver.sv
// Bench for acc_display_driver with a short refresh period and a decimal
// reference model of what each display position should show.
module tb_acc_display_driver;

  localparam int DIV = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] VALUE = 16'd0;
  logic        LOAD = 1'b0;
  logic        BUSY;
  logic        DONE;
  logic [6:0]  SEG;
  logic [5:0]  AN;

  int checks = 0;
  int errors = 0;

  logic [6:0] obs_seg[6];
  logic [5:0] seen;
  logic [6:0] codes[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  acc_display_driver #(.REFRESH_DIV(DIV), .NUM_DIGITS(6)) dut (
    .CLK(CLK), .RST(RST), .VALUE(VALUE), .LOAD(LOAD),
    .BUSY(BUSY), .DONE(DONE), .SEG(SEG), .AN(AN)
  );

  always #5 CLK = ~CLK;

  // Reference: decimal digits of |v|, sign just above the top digit.
  function automatic logic [6:0] model_seg(int v, int pos);
    int a, n, t, p;
    a = (v < 0) ? -v : v;
    n = 1;
    t = a / 10;
    while (t > 0) begin n++; t = t / 10; end
    if (pos < n) begin
      p = 1;
      for (int i = 0; i < pos; i++) p = p * 10;
      return codes[(a / p) % 10];
    end
    if (pos == n && v < 0) return 7'h3F;
    return 7'h7F;
  endfunction

  task automatic scan_display();
    seen = 6'd0;
    for (int c = 0; c < 8 * DIV; c++) begin
      @(negedge CLK);
      for (int i = 0; i < 6; i++) begin
        if (AN == ~(6'd1 << i)) begin
          obs_seg[i] = SEG;
          seen[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_display(int v, string tag);
    scan_display();
    checks++;
    if (seen !== 6'h3F) begin
      errors++;
      $display("FAIL %s scan_coverage got %b want 111111", tag, seen);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs_seg[i] !== model_seg(v, i)) begin
        errors++;
        $display("FAIL %s digit%0d value %0d got %h want %h", tag, i, v,
                 obs_seg[i], model_seg(v, i));
      end
    end
  endtask

  // Pulse LOAD; on return the capture edge has passed (negedge after it).
  task automatic pulse_load(int v);
    @(negedge CLK);
    VALUE = 16'(v);
    LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
  endtask

  task automatic test_value(int v, string tag);
    int busy_n, done_n;
    busy_n = 0;
    done_n = 0;
    pulse_load(v);
    for (int i = 0; i < 24; i++) begin
      if (BUSY) busy_n++;
      if (DONE) done_n++;
      @(negedge CLK);
    end
    checks++;
    if (busy_n != 17) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d want 17", tag, busy_n);
    end
    checks++;
    if (done_n != 1) begin
      errors++;
      $display("FAIL %s done_pulses got %0d want 1", tag, done_n);
    end
    compare_display(v, tag);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    checks++;
    if (AN !== 6'b111110 || SEG !== 7'h40 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got AN=%b SEG=%h BUSY=%b DONE=%b want 111110 40 0 0",
               AN, SEG, BUSY, DONE);
    end
    repeat (DIV - 1) @(posedge CLK);
    #1;
    checks++;
    if (AN !== 6'b111110) begin
      errors++;
      $display("FAIL reset_hold got AN=%b want 111110", AN);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (AN !== 6'b111101 || SEG !== 7'h7F) begin
      errors++;
      $display("FAIL reset_first_wrap got AN=%b SEG=%h want 111101 7f", AN, SEG);
    end
  endtask

  task automatic test_directed();
    test_value(1234, "v1234");
    test_value(-32768, "vmin");
    test_value(32767, "vmax");
    test_value(-7, "vneg7");
    test_value(0, "vzero");
    test_value(-10000, "vneg10000");
  endtask

  task automatic test_random();
    logic signed [15:0] r;
    for (int n = 0; n < 8; n++) begin
      r = 16'($urandom);
      test_value(int'(r), "rand");
    end
  endtask

  task automatic test_busy_drop();
    int done_n;
    done_n = 0;
    pulse_load(5);
    repeat (3) @(negedge CLK);
    VALUE = 16'd9;
    LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (DONE) done_n++;
      @(negedge CLK);
    end
    checks++;
    if (done_n != 1) begin
      errors++;
      $display("FAIL drop_done_count got %0d want 1", done_n);
    end
    compare_display(5, "drop");
  endtask

  task automatic test_back_to_back();
    bit got;
    got = 1'b0;
    pulse_load(42);
    for (int i = 0; i < 30 && !got; i++) begin
      if (DONE) got = 1'b1;
      else @(negedge CLK);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL b2b_first_done got timeout want DONE");
    end
    VALUE = 16'd9;
    LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got BUSY=%b want 1", BUSY);
    end
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (DONE) got = 1'b1;
      else @(negedge CLK);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL b2b_second_done got timeout want DONE");
    end
    compare_display(9, "b2b");
  endtask

  task automatic test_reset_mid();
    int done_n;
    done_n = 0;
    pulse_load(321);
    repeat (7) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0 || AN !== 6'b111110 || SEG !== 7'h40) begin
      errors++;
      $display("FAIL midreset_state got BUSY=%b AN=%b SEG=%h want 0 111110 40",
               BUSY, AN, SEG);
    end
    RST = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (DONE) done_n++;
      @(negedge CLK);
    end
    checks++;
    if (done_n != 0) begin
      errors++;
      $display("FAIL midreset_done got %0d want 0", done_n);
    end
    compare_display(0, "midreset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_drop();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_display_driver.md
# acc_display_driver

Downstream output stage of the calculator core. It captures the signed 16-bit accumulator value on a load strobe, converts its magnitude to five BCD digits with a sequential double-dabble converter, and shows sign plus digits on a six-digit multiplexed common-anode 7-segment display. Leading zeros are blanked, and the old value stays on the display until conversion finishes, so the display never shows a partial result.

## Interface
Parameters:
- REFRESH_DIV, 50000: clock cycles each digit stays lit; must be ≥ 2.
- NUM_DIGITS, 6: display positions; fixed at 6 (sign + 5 magnitude digits).

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  reset; synchronous, active-low.
- VALUE  in  16  signed accumulator value to display.
- LOAD  in  1  one-cycle capture strobe, driven from the accumulator write enable.
- BUSY  out  1  conversion in progress; LOAD is ignored while high.
- DONE  out  1  one-cycle pulse when the new value is committed to the display.
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
- AN  out  6  digit enables, active-low one-hot; AN[0] is the rightmost digit.

## Operation
- FSM states and transitions:
  - IDLE → SHIFT on LOAD.
  - SHIFT → COMMIT after 16 iterations.
  - COMMIT → IDLE.
- Capture (IDLE with LOAD high):
  - neg = VALUE[15].
  - mag = neg ? (~VALUE + 1) : VALUE, held as 16-bit unsigned. -32768 gives 0x8000 (32768), which is correct.
  - BCD register (20 bits) is cleared; iteration counter is cleared.
- SHIFT, once per cycle for 16 cycles:
  - add 3 to every BCD nibble ≥ 5;
  - then shift {bcd, mag} left by one.
- COMMIT: disp_bcd ← bcd and disp_neg ← neg; DONE = 1 for this cycle only.
- Display mapping:
  - digits 0–4 show disp_bcd nibbles 0–4;
  - msd is the highest nonzero nibble (0 if all nibbles are zero);
  - digits above msd are blank (SEG = 7'h7F);
  - if disp_neg and the value is nonzero, digit msd+1 shows minus (SEG = 7'h3F); the remaining higher digits stay blank;
  - value 0 shows a single "0" with no sign.
- Segment codes (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).
- Scanning:
  - a refresh counter counts 0..REFRESH_DIV-1;
  - on wrap, the digit index advances 0→5 and then returns to 0;
  - AN = ~(1 << idx); SEG is decoded from the current idx.
- LOAD handling:
  - LOAD while BUSY (SHIFT or COMMIT) is dropped, not queued.
  - LOAD in the cycle after COMMIT (IDLE) is accepted.

## Timing
- LOAD is sampled at edge k.
- BUSY is high from edge k to edge k+17.
- Display registers update at edge k+17; DONE is high during the cycle after edge k+17.
- Conversion latency is 17 cycles. Maximum throughput is one value per 18 cycles.
- SEG/AN are registered and change only at refresh wraps or at commit.
- Reset values:
  - state IDLE; BUSY 0; DONE 0;
  - disp_bcd 0; disp_neg 0;
  - refresh counter 0; idx 0;
  - AN = 6'b111110; SEG = 7'h40 (shows "0").
- Reset mid-conversion aborts the conversion. The display returns to "0" and the captured value is lost.

## Structure
- Shared package holds:
  - the FSM state enum {IDLE, SHIFT, COMMIT};
  - the segment-code constants (digits 0–9, BLANK, MINUS);
  - NUM_MAG_DIGITS = 5.
- Sub-module bin2bcd_dd holds the sequential double-dabble converter. Its ports are CLK, RST, START, BIN[15:0], BUSY, VALID and BCD[19:0].
- The top level holds:
  - sign/abs capture;
  - display registers;
  - leading-zero and sign placement;
  - refresh scan.

## Test plan
- Reset → AN=111110, SEG=40, BUSY=0; after REFRESH_DIV cycles AN=111101, SEG=7F.
- LOAD VALUE=1234 → BUSY for 17 cycles, DONE once; scan shows 4,3,2,1 on digits 0–3 and blank on digits 4–5.
- LOAD VALUE=-32768 → digits 0–4 show 8,6,7,2,3 and digit 5 shows minus (3F). Same check for 32767 with digit 5 blank.
- LOAD VALUE=-7 → digit 0 = 78, digit 1 = 3F, digits 2–5 = 7F. LOAD 0 → digit 0 = 40, rest blank, no minus.
- LOAD 5, then LOAD 9 on cycle 5 (busy) → only 5 is displayed and one DONE is seen. LOAD 9 the cycle after COMMIT → 9 is displayed.
- Assert RST at SHIFT cycle 8 → next cycle BUSY=0 and "0" is displayed; no DONE is ever seen.
